// File: rtl/mem_addr_seq.sv
`default_nettype none
// ============================================================================
// Module      : mem_addr_seq
// Description : Memory-address source selector and burst sequencer.
//               A base address is picked from one of N_SRC external buses or
//               one of N_VEC fixed vector constants (VEC_BASE + k). It is
//               registered and then stepped by STRIDE for up to MAX_BEATS
//               beats, with a hold/stall input and a final-beat flag.
//
// Optional    : ADDR_ALIGN_EN - when defined, the low log2(STRIDE) bits of
//               the base are cleared before load and align_err pulses with
//               the first beat if any of them were set. When undefined, the
//               base is loaded unchanged and align_err stays 0.
//
// Ports       :
//   clk        in   1            rising-edge clock
//   reset      in   1            synchronous, active-high reset
//   src_bus    in   N_SRC*WIDTH  source k at [k*WIDTH +: WIDTH]
//   sel        in   SEL_W        0..N_SRC-1 external, N_SRC..N_SRC+N_VEC-1
//                                vector constant, anything else invalid
//   start      in   1            burst request, sampled only in IDLE
//   beats      in   CNT_W        burst length, sampled with start
//   hold       in   1            freeze the current beat
//   addr_out   out  WIDTH        registered address
//   addr_valid out  1            addr_out is a live beat
//   busy       out  1            burst in progress
//   last       out  1            current beat is the final beat
//   sel_err    out  1            one-cycle pulse: start with invalid sel
//   align_err  out  1            one-cycle pulse with first beat: base was
//                                not STRIDE-aligned
//
// Revision    : 1.0 - initial release
// ============================================================================
module mem_addr_seq #(
   parameter int WIDTH     = 32,
   parameter int N_SRC     = 4,
   parameter int N_VEC     = 3,
   parameter int VEC_BASE  = 253,
   parameter int SEL_W     = 3,
   parameter int STRIDE    = 4,
   parameter int MAX_BEATS = 4,
   parameter int CNT_W     = 3
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [N_SRC*WIDTH-1:0] src_bus,
   input  logic [SEL_W-1:0]       sel,
   input  logic                   start,
   input  logic [CNT_W-1:0]       beats,
   input  logic                   hold,
   output logic [WIDTH-1:0]       addr_out,
   output logic                   addr_valid,
   output logic                   busy,
   output logic                   last,
   output logic                   sel_err,
   output logic                   align_err
);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } state_t;

   state_t           state;
   state_t           state_nx;

   // Beats still to present after the current one.
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_nx;

   logic [WIDTH-1:0] addr_nx;
   logic             valid_nx;
   logic             busy_nx;
   logic             last_nx;
   logic             sel_err_nx;
   logic             align_err_nx;

   // ------------------------------------------------------------------------
   // Base address selection
   // ------------------------------------------------------------------------
   // One extra bit so comparisons against N_SRC+N_VEC never overflow SEL_W.
   logic [SEL_W:0]   sel_ext;
   logic             sel_is_src;
   logic             sel_valid;
   logic [WIDTH-1:0] src_base;
   logic [WIDTH-1:0] vec_base;
   logic [WIDTH-1:0] base;
   logic [WIDTH-1:0] load_base;
   logic             load_misalign;

   assign sel_ext    = {1'b0, sel};
   assign sel_is_src = (sel_ext < (SEL_W+1)'(N_SRC));
   assign sel_valid  = (sel_ext < (SEL_W+1)'(N_SRC + N_VEC));

   always_comb begin
      src_base = '0;
      for (int k = 0; k < N_SRC; k++) begin
         if (sel_ext == (SEL_W+1)'(k)) begin
            src_base = src_bus[k*WIDTH +: WIDTH];
         end
      end
   end

   // Only consumed when sel is a vector index, so the subtraction is
   // non-negative whenever the result matters.
   assign vec_base = WIDTH'(VEC_BASE) + WIDTH'(sel_ext - (SEL_W+1)'(N_SRC));
   assign base     = sel_is_src ? src_base : vec_base;

`ifdef ADDR_ALIGN_EN
   localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(STRIDE - 1);

   assign load_base     = base & ~ALIGN_MASK;
   assign load_misalign = |(base & ALIGN_MASK);
`else
   assign load_base     = base;
   assign load_misalign = 1'b0;
`endif

   // ------------------------------------------------------------------------
   // Burst length normalisation: 0 means a single beat, oversize clamps.
   // ------------------------------------------------------------------------
   logic [CNT_W-1:0] beats_eff;

   always_comb begin
      if (beats == '0) begin
         beats_eff = CNT_W'(1);
      end else if (beats > CNT_W'(MAX_BEATS)) begin
         beats_eff = CNT_W'(MAX_BEATS);
      end else begin
         beats_eff = beats;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state and next-output logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_nx     = state;
      count_nx     = count;
      addr_nx      = addr_out;
      valid_nx     = addr_valid;
      busy_nx      = busy;
      last_nx      = last;
      sel_err_nx   = 1'b0;
      align_err_nx = 1'b0;

      case (state)
         ST_IDLE: begin
            if (start) begin
               if (sel_valid) begin
                  state_nx     = ST_BURST;
                  addr_nx      = load_base;
                  valid_nx     = 1'b1;
                  busy_nx      = 1'b1;
                  last_nx      = (beats_eff == CNT_W'(1));
                  count_nx     = beats_eff - CNT_W'(1);
                  align_err_nx = load_misalign;
               end else begin
                  // Rejected request leaves addr_out untouched.
                  sel_err_nx = 1'b1;
               end
            end
         end

         ST_BURST: begin
            // start/sel/beats are deliberately ignored here.
            if (!hold) begin
               if (last) begin
                  // addr_out keeps the final beat's address.
                  state_nx = ST_IDLE;
                  valid_nx = 1'b0;
                  busy_nx  = 1'b0;
                  last_nx  = 1'b0;
               end else begin
                  addr_nx  = addr_out + WIDTH'(STRIDE);
                  count_nx = count - CNT_W'(1);
                  last_nx  = (count == CNT_W'(1));
               end
            end
         end

         default: begin
            state_nx = ST_IDLE;
            valid_nx = 1'b0;
            busy_nx  = 1'b0;
            last_nx  = 1'b0;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // State and output registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         count      <= '0;
         addr_out   <= '0;
         addr_valid <= 1'b0;
         busy       <= 1'b0;
         last       <= 1'b0;
         sel_err    <= 1'b0;
         align_err  <= 1'b0;
      end else begin
         state      <= state_nx;
         count      <= count_nx;
         addr_out   <= addr_nx;
         addr_valid <= valid_nx;
         busy       <= busy_nx;
         last       <= last_nx;
         sel_err    <= sel_err_nx;
         align_err  <= align_err_nx;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_addr_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_addr_seq
// Description : Table-driven self-checking bench for mem_addr_seq with the
//               default parameter set. Each table record is one clock cycle:
//               inputs driven on the falling edge, outputs compared 1 time
//               unit after the following rising edge. A hand-written sequence
//               covers a long stall and a bounded wait for burst completion.
//               Expected values follow ADDR_ALIGN_EN when it is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_addr_seq;

   logic         clk = 1'b0;
   logic         reset;
   logic [127:0] src_bus;
   logic [2:0]   sel;
   logic         start;
   logic [2:0]   beats;
   logic         hold;
   logic [31:0]  addr_out;
   logic         addr_valid;
   logic         busy;
   logic         last;
   logic         sel_err;
   logic         align_err;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   mem_addr_seq dut (
      .clk        (clk),
      .reset      (reset),
      .src_bus    (src_bus),
      .sel        (sel),
      .start      (start),
      .beats      (beats),
      .hold       (hold),
      .addr_out   (addr_out),
      .addr_valid (addr_valid),
      .busy       (busy),
      .last       (last),
      .sel_err    (sel_err),
      .align_err  (align_err)
   );

`ifdef ADDR_ALIGN_EN
   localparam bit ALN = 1'b1;
`else
   localparam bit ALN = 1'b0;
`endif

   // Expected loaded base and alignment flag for a raw base address.
   function automatic logic [31:0] fa(input logic [31:0] a);
      return ALN ? (a & ~32'h3) : a;
   endfunction

   function automatic logic fe(input logic [31:0] a);
      return ALN && (a[1:0] != 2'b00);
   endfunction

   typedef struct {
      string       name;
      logic        rst;
      logic        st;
      logic [2:0]  sl;
      logic [2:0]  bt;
      logic        hd;
      logic [31:0] s0;
      logic [31:0] s1;
      logic [31:0] e_addr;
      logic        e_v;
      logic        e_b;
      logic        e_l;
      logic        e_se;
      logic        e_ae;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input string n, input logic r, input logic st,
                      input logic [2:0] sl, input logic [2:0] bt,
                      input logic hd, input logic [31:0] s0,
                      input logic [31:0] s1, input logic [31:0] ea,
                      input logic ev, input logic eb, input logic el,
                      input logic es, input logic eae);
      vec_t v;
      v = '{n, r, st, sl, bt, hd, s0, s1, ea, ev, eb, el, es, eae};
      tbl.push_back(v);
   endtask

   task automatic check(input string n, input logic [31:0] ea, input logic ev,
                        input logic eb, input logic el, input logic es,
                        input logic eae);
      nvec++;
      if (addr_out !== ea || addr_valid !== ev || busy !== eb ||
          last !== el || sel_err !== es || align_err !== eae) begin
         nerr++;
         $display("FAIL %s: got addr=%h v=%b b=%b l=%b se=%b ae=%b, want addr=%h v=%b b=%b l=%b se=%b ae=%b",
                  n, addr_out, addr_valid, busy, last, sel_err, align_err,
                  ea, ev, eb, el, es, eae);
      end
   endtask

   localparam logic [31:0] S1 = 32'h0000_0100;
   localparam logic [31:0] S2 = 32'h0000_0200;
   localparam logic [31:0] S3 = 32'h0000_0300;

   initial begin
      reset   = 1'b1;
      src_bus = '0;
      sel     = '0;
      start   = 1'b0;
      beats   = '0;
      hold    = 1'b0;

      // name       rst st sel bt hd  s0            s1            exp_addr             v  b  l  se ae
      // Reset held two cycles
      add("rst0",    1, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0,               0, 0, 0, 0, 0);
      add("rst1",    1, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0,               0, 0, 0, 0, 0);
      // Four-beat burst from src1, with a start/invalid sel ignored mid-burst
      add("b4_0",    0, 1, 1, 4, 0, 32'h0,         S1,            32'h100,             1, 1, 0, 0, 0);
      add("b4_1",    0, 0, 1, 4, 0, 32'h0,         S1,            32'h104,             1, 1, 0, 0, 0);
      add("b4_ign",  0, 1, 7, 1, 0, 32'h0,         S1,            32'h108,             1, 1, 0, 0, 0);
      add("b4_3",    0, 0, 1, 4, 0, 32'h0,         S1,            32'h10C,             1, 1, 1, 0, 0);
      add("b4_end",  0, 0, 1, 4, 0, 32'h0,         S1,            32'h10C,             0, 0, 0, 0, 0);
      // Vector sel=5 (254): beats 1, 0 and 7
      add("v5_b1",   0, 1, 5, 1, 0, 32'h0,         S1,            fa(254),             1, 1, 1, 0, fe(254));
      add("v5_b1e",  0, 0, 5, 1, 0, 32'h0,         S1,            fa(254),             0, 0, 0, 0, 0);
      add("v5_b0",   0, 1, 5, 0, 0, 32'h0,         S1,            fa(254),             1, 1, 1, 0, fe(254));
      add("v5_b0e",  0, 0, 5, 0, 0, 32'h0,         S1,            fa(254),             0, 0, 0, 0, 0);
      add("v5_b7_0", 0, 1, 5, 7, 0, 32'h0,         S1,            fa(254),             1, 1, 0, 0, fe(254));
      add("v5_b7_1", 0, 0, 5, 7, 0, 32'h0,         S1,            fa(254) + 32'd4,     1, 1, 0, 0, 0);
      add("v5_b7_2", 0, 0, 5, 7, 0, 32'h0,         S1,            fa(254) + 32'd8,     1, 1, 0, 0, 0);
      add("v5_b7_3", 0, 0, 5, 7, 0, 32'h0,         S1,            fa(254) + 32'd12,    1, 1, 1, 0, 0);
      add("v5_b7_e", 0, 0, 5, 7, 0, 32'h0,         S1,            fa(254) + 32'd12,    0, 0, 0, 0, 0);
      add("v6_b1",   0, 1, 6, 1, 0, 32'h0,         S1,            fa(255),             1, 1, 1, 0, fe(255));
      add("v6_b1e",  0, 0, 6, 1, 0, 32'h0,         S1,            fa(255),             0, 0, 0, 0, 0);
      // Hold while 0x104 shown; src1 changes mid-burst; hold on the last beat
      add("h_0",     0, 1, 1, 4, 0, 32'h0,         S1,            32'h100,             1, 1, 0, 0, 0);
      add("h_1",     0, 0, 1, 4, 0, 32'h0,         S1,            32'h104,             1, 1, 0, 0, 0);
      add("h_2",     0, 0, 1, 4, 1, 32'h0,         S1,            32'h104,             1, 1, 0, 0, 0);
      add("h_3",     0, 0, 1, 4, 1, 32'h0,         32'hDEAD0000,  32'h104,             1, 1, 0, 0, 0);
      add("h_4",     0, 0, 1, 4, 0, 32'h0,         32'hDEAD0000,  32'h108,             1, 1, 0, 0, 0);
      add("h_5",     0, 0, 1, 4, 0, 32'h0,         32'hDEAD0000,  32'h10C,             1, 1, 1, 0, 0);
      add("h_6",     0, 0, 1, 4, 1, 32'h0,         32'hDEAD0000,  32'h10C,             1, 1, 1, 0, 0);
      add("h_7",     0, 0, 1, 4, 0, 32'h0,         32'hDEAD0000,  32'h10C,             0, 0, 0, 0, 0);
      // Invalid sel, address wrap, start ignored on final edge, back-to-back
      add("serr",    0, 1, 7, 2, 0, 32'h0,         S1,            32'h10C,             0, 0, 0, 1, 0);
      add("serr_e",  0, 0, 7, 2, 0, 32'h0,         S1,            32'h10C,             0, 0, 0, 0, 0);
      add("wrap_0",  0, 1, 0, 2, 0, 32'hFFFFFFFC,  S1,            32'hFFFFFFFC,        1, 1, 0, 0, 0);
      add("wrap_1",  0, 0, 0, 2, 0, 32'hFFFFFFFC,  S1,            32'h0,               1, 1, 1, 0, 0);
      add("wrap_st", 0, 1, 4, 1, 0, 32'hFFFFFFFC,  S1,            32'h0,               0, 0, 0, 0, 0);
      add("b2b",     0, 1, 4, 1, 0, 32'hFFFFFFFC,  S1,            fa(253),             1, 1, 1, 0, fe(253));
      add("b2b_e",   0, 0, 4, 1, 0, 32'hFFFFFFFC,  S1,            fa(253),             0, 0, 0, 0, 0);
      // Reset mid-burst, then misaligned external base
      add("r_0",     0, 1, 1, 4, 0, 32'h0,         S1,            32'h100,             1, 1, 0, 0, 0);
      add("r_1",     0, 0, 1, 4, 0, 32'h0,         S1,            32'h104,             1, 1, 0, 0, 0);
      add("r_rst",   1, 0, 1, 4, 0, 32'h0,         S1,            32'h0,               0, 0, 0, 0, 0);
      add("r_idle",  0, 0, 1, 4, 0, 32'h0,         S1,            32'h0,               0, 0, 0, 0, 0);
      add("al_0",    0, 1, 0, 1, 0, 32'h102,       S1,            fa(32'h102),         1, 1, 1, 0, fe(32'h102));
      add("al_e",    0, 0, 0, 1, 0, 32'h102,       S1,            fa(32'h102),         0, 0, 0, 0, 0);

      foreach (tbl[i]) begin
         @(negedge clk);
         reset   = tbl[i].rst;
         start   = tbl[i].st;
         sel     = tbl[i].sl;
         beats   = tbl[i].bt;
         hold    = tbl[i].hd;
         src_bus = {S3, S2, tbl[i].s1, tbl[i].s0};
         @(posedge clk);
         #1;
         check(tbl[i].name, tbl[i].e_addr, tbl[i].e_v, tbl[i].e_b,
               tbl[i].e_l, tbl[i].e_se, tbl[i].e_ae);
      end

      // Hand-written: 3-beat burst from src3 stalled on its first beat,
      // then a bounded wait for busy to drop.
      begin
         int edges;
         @(negedge clk);
         reset = 1'b0;
         start = 1'b1;
         sel   = 3'd3;
         beats = 3'd3;
         hold  = 1'b0;
         @(posedge clk);
         #1;
         check("hw_first", 32'h300, 1, 1, 0, 0, 0);
         @(negedge clk);
         start = 1'b0;
         hold  = 1'b1;
         for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check("hw_hold", 32'h300, 1, 1, 0, 0, 0);
         end
         @(negedge clk);
         hold  = 1'b0;
         edges = 0;
         while (busy && edges < 10) begin
            @(posedge clk);
            #1;
            edges++;
         end
         nvec++;
         if (busy || edges != 3) begin
            nerr++;
            $display("FAIL hw_done: got busy=%b after %0d edges, want busy=0 after 3 edges",
                     busy, edges);
         end
         check("hw_final", 32'h308, 0, 0, 0, 0, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
`default_nettype wire
